// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcodes, loader bundle kinds, loader states.
// Imported by the instruction packer, the loader and the core decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_LW   = 3'd1;
    localparam logic [2:0] KIND_SW   = 3'd2;
    localparam logic [2:0] KIND_ADDI = 3'd3;
    localparam logic [2:0] KIND_BEQ  = 3'd4;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } ldr_state_e;

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: kind + fields -> 32-bit MIPS word, legal flag.
// Ports: kind, rs, rt, rd, shamt, funct, imm in; word, legal out.
module mips_instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        unique case (1'b1)
            (kind == KIND_R):
                word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            (kind == KIND_LW):
                word = {OP_LW, rs, rt, imm};
            (kind == KIND_SW):
                word = {OP_SW, rs, rt, imm};
            (kind == KIND_ADDI):
                word = {OP_ADDI, rs, rt, imm};
            (kind == KIND_BEQ):
                word = {OP_BEQ, rs, rt, imm};
            default:
                legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_imem_loader.sv
// Streams field bundles in, packs them, writes consecutive imem words.
// Ports: in_* valid/ready stream, imem_* req/gnt write, count/full/err_*.
module mips_imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    output logic              imem_req,
    input  logic              imem_gnt,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    ldr_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;
    logic              pend_q, pend_d;

    logic [31:0]       word;
    logic              legal;
    logic              accept;

    mips_instr_pack u_pack (
        .kind  (in_kind),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .shamt (in_shamt),
        .funct (in_funct),
        .imm   (in_imm),
        .word  (word),
        .legal (legal)
    );

    assign full     = (count_q == DEPTH_C);
    assign in_ready = (state_q == S_IDLE) && !full && !clear;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    count_d = '0;
                    addr_d  = BASE_C;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                end else if (in_valid && full) begin
                    ovf_d = 1'b1;
                end else if (accept) begin
                    if (legal) begin
                        wdata_d = word;
                        addr_d  = BASE_C + count_q[ADDR_W-1:0];
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (clear) begin
                    pend_d = 1'b1;
                end
                if (imem_gnt) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    // A clear seen during the write lands as we go idle.
                    if (pend_q || clear) begin
                        count_d = '0;
                        addr_d  = BASE_C;
                        ill_d   = 1'b0;
                        ovf_d   = 1'b0;
                        pend_d  = 1'b0;
                    end else if (!full) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= '0;
            count_q <= '0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign count        = count_q;
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Bench for mips_imem_loader: directed program loads plus random traffic.
// A transaction-level model predicts every output on every cycle.
module tb_mips_imem_loader;

    localparam int AW    = 8;
    localparam int DEP   = 5;
    localparam int BASE  = 'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm = '0;
    logic        imem_req;
    logic        imem_gnt = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [AW:0] count;
    logic        full;
    logic        err_illegal;
    logic        err_overflow;

    mips_imem_loader #(
        .ADDR_W    (AW),
        .DEPTH     (DEP),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_kind      (in_kind),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_shamt     (in_shamt),
        .in_funct     (in_funct),
        .in_imm       (in_imm),
        .imem_req     (imem_req),
        .imem_gnt     (imem_gnt),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .count        (count),
        .full         (full),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model: a write is outstanding or not, plus counters and flags
    int          m_busy, m_pend, m_count, m_ill, m_ovf;
    int          m_addr;
    logic [31:0] m_word;

    typedef struct {
        int          a;
        logic [31:0] w;
    } wr_t;
    wr_t wlog[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int k, input int rs,
                                        input int rt, input int rd,
                                        input int sh, input int fn,
                                        input int imm);
        int op[5] = '{0, 'h23, 'h2B, 'h08, 'h04};
        int lo;
        lo = (k == 0) ? (rd * 2048 + sh * 64 + fn) : imm;
        return 32'(op[k]) * 32'd67108864 + 32'(rs) * 32'd2097152
             + 32'(rt) * 32'd65536 + 32'(lo);
    endfunction

    task automatic m_reset();
        m_busy = 0; m_pend = 0; m_count = 0;
        m_ill = 0; m_ovf = 0; m_addr = BASE; m_word = '0;
    endtask

    task automatic m_clear();
        m_count = 0; m_addr = BASE; m_ill = 0; m_ovf = 0; m_pend = 0;
    endtask

    // one cycle: drive at negedge, check, advance model, wait a cycle
    task automatic cyc(input logic v, input int k, input int rs,
                       input int rt, input int rd, input int sh,
                       input int fn, input int imm, input logic g,
                       input logic c);
        bit exp_rdy;
        in_valid = v; in_kind = 3'(k); in_rs = 5'(rs); in_rt = 5'(rt);
        in_rd = 5'(rd); in_shamt = 5'(sh); in_funct = 6'(fn);
        in_imm = 16'(imm); imem_gnt = g; clear = c;
        #1;
        exp_rdy = (m_busy == 0) && (m_count != DEP) && !c;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("imem_req", 32'(imem_req), 32'(m_busy));
        chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("imem_wdata", imem_wdata, m_word);
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == DEP));
        chk("err_illegal", 32'(err_illegal), 32'(m_ill));
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        if (imem_req && g) wlog.push_back('{int'(imem_addr), imem_wdata});
        if (m_busy == 0) begin
            if (c) m_clear();
            else if (v && m_count == DEP) m_ovf = 1;
            else if (v && k > 4) m_ill = 1;
            else if (v) begin
                m_busy = 1;
                m_addr = BASE + m_count;
                m_word = enc(k, rs, rt, rd, sh, fn, imm);
            end
        end else begin
            if (c) m_pend = 1;
            if (g) begin
                m_busy = 0;
                if (m_count < DEP) m_count++;
                if (m_pend) m_clear();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic put(input int k, input int rs, input int rt,
                       input int rd, input int fn, input int imm,
                       input int dly);
        cyc(1, k, rs, rt, rd, 0, fn, imm, 0, 0);
        for (int i = 0; i < dly; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic chk_wr(input string nm, input int idx, input int a,
                          input logic [31:0] w);
        if (idx >= wlog.size()) begin
            chk({nm, "_present"}, 32'(wlog.size()), 32'(idx + 1));
        end else begin
            chk({nm, "_addr"}, 32'(wlog[idx].a), 32'(a));
            chk({nm, "_data"}, wlog[idx].w, w);
        end
    endtask

    int n0;

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h10);
        chk("rst_wdata", imem_wdata, 32'd0);
        rst_n = 1'b1;
        idle();

        put(0, 1, 2, 3, 'h20, 0, 0);
        chk("ready_2cyc", 32'(in_ready), 32'd1);
        chk_wr("add", 0, 'h10, 32'h00221820);
        chk("add_count", 32'(count), 32'd1);

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("clr_idle", 32'(count), 32'd0);
        n0 = wlog.size();
        put(1, 9, 8, 0, 0, 4, 0);
        put(2, 9, 8, 0, 0, 8, 0);
        put(3, 0, 5, 0, 0, 'hFFFF, 0);
        put(4, 1, 2, 0, 0, 'hFFFE, 0);
        chk_wr("lw", n0, 'h10, 32'h8D280004);
        chk_wr("sw", n0 + 1, 'h11, 32'hAD280008);
        chk_wr("addi", n0 + 2, 'h12, 32'h2005FFFF);
        chk_wr("beq", n0 + 3, 'h13, 32'h1022FFFE);
        chk("prog_count", 32'(count), 32'd4);

        put(0, 4, 5, 6, 'h22, 0, 3);
        chk("slow_count", 32'(count), 32'd5);
        chk("full", 32'(full), 32'd1);
        cyc(1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("ovf", 32'(err_overflow), 32'd1);
        chk("ovf_noreq", 32'(imem_req), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("clr_full", 32'(full), 32'd0);
        chk("clr_ovf", 32'(err_overflow), 32'd0);

        cyc(1, 6, 1, 2, 3, 0, 0, 0, 0, 0);
        chk("ill_flag", 32'(err_illegal), 32'd1);
        chk("ill_noreq", 32'(imem_req), 32'd0);
        n0 = wlog.size();
        put(3, 1, 1, 0, 0, 7, 0);
        chk_wr("after_ill", n0, 'h10, 32'h20210007);

        cyc(1, 1, 2, 3, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("clr_req", 32'(count), 32'd0);
        chk("clr_req_ill", 32'(err_illegal), 32'd0);

        put(0, 1, 1, 1, 0, 0, 0);
        cyc(1, 2, 3, 4, 0, 0, 0, 9, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7)
                                            : $urandom_range(0, 4),
                $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 63), $urandom_range(0, 65535),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
